// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - ALU/LSU writeback arbiter with busy scoreboard and hazard detect.
// Optional forwarding outputs are enabled by defining WB_BYPASS_EN.
module reg_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        hazard,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        write_en,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] busy
`ifdef WB_BYPASS_EN
  ,
  output logic        rs1_fwd,
  output logic        rs2_fwd,
  output logic [31:0] fwd_data
`endif
);

  logic        r_ptr;        // 0: ALU preferred, 1: LSU preferred
  logic        r_write_en;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rd_data;
  logic [31:0] r_busy;

  logic        w_alu_xfer;
  logic        w_lsu_xfer;
  logic        w_xfer;
  logic [4:0]  w_xfer_rd;
  logic [31:0] w_xfer_data;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic        w_rs1_busy;
  logic        w_rs2_busy;
  logic        w_issue_busy;

  // Grants are masked while in reset so no handshake can complete then.
  assign alu_ready = rst & alu_valid & (~lsu_valid | ~r_ptr);
  assign lsu_ready = rst & lsu_valid & (~alu_valid | r_ptr);

  assign w_alu_xfer  = alu_valid & alu_ready;
  assign w_lsu_xfer  = lsu_valid & lsu_ready;
  assign w_xfer      = w_alu_xfer | w_lsu_xfer;
  assign w_xfer_rd   = w_lsu_xfer ? lsu_rd : alu_rd;
  assign w_xfer_data = w_lsu_xfer ? lsu_data : alu_data;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (issue_valid && (issue_rd != 5'd0)) w_set_mask[issue_rd] = 1'b1;
    if (w_xfer && (w_xfer_rd != 5'd0))     w_clr_mask[w_xfer_rd] = 1'b1;
  end

  assign w_rs1_busy   = (rs1_addr != 5'd0) & r_busy[rs1_addr];
  assign w_rs2_busy   = (rs2_addr != 5'd0) & r_busy[rs2_addr];
  assign w_issue_busy = issue_valid & (issue_rd != 5'd0) & r_busy[issue_rd];

  // A committed write has already cleared its busy bit, so a forwarded source never
  // contributes to hazard; a re-issued register keeps stalling until its new write lands.
  assign hazard = w_rs1_busy | w_rs2_busy | w_issue_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= 1'b0;
      r_write_en <= 1'b0;
      r_rd_addr  <= 5'd0;
      r_rd_data  <= 32'd0;
      r_busy     <= 32'd0;
    end else begin
      r_busy     <= ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
      r_write_en <= w_xfer && (w_xfer_rd != 5'd0);
      if (w_xfer && (w_xfer_rd != 5'd0)) begin
        r_rd_addr <= w_xfer_rd;
        r_rd_data <= w_xfer_data;
      end
      if (w_xfer && alu_valid && lsu_valid) r_ptr <= ~r_ptr;
    end
  end

  assign write_en = r_write_en;
  assign rd_addr  = r_rd_addr;
  assign rd_data  = r_rd_data;
  assign busy     = r_busy;

`ifdef WB_BYPASS_EN
  assign rs1_fwd  = r_write_en & (rs1_addr != 5'd0) & (rs1_addr == r_rd_addr);
  assign rs2_fwd  = r_write_en & (rs2_addr != 5'd0) & (rs2_addr == r_rd_addr);
  assign fwd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed self-checking bench for reg_writeback.
`timescale 1ns/1ps
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        hazard;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        write_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] busy;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd;
  logic        rs2_fwd;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .write_en(write_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
`ifdef WB_BYPASS_EN
    , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_alu [4];
    logic [4:0] exp_rd [4];
    exp_alu = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_rd  = '{5'd1, 5'd2, 5'd1, 5'd2};

    rst = 1'b0; issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0; lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    #12;
    check("reset_write_en", write_en, 1'b0);
    check("reset_rd_addr", rd_addr, 5'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_busy", busy, 32'd0);
    check("reset_hazard", hazard, 1'b0);
    @(negedge clk); rst = 1'b1;
    step();

    issue_valid = 1; issue_rd = 5;
    step();
    issue_valid = 0; issue_rd = 0;
    check("issue5_busy", busy, 32'h0000_0020);
    rs1_addr = 5; #1;
    check("issue5_hazard_rs1", hazard, 1'b1);
    rs1_addr = 0; alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; #1;
    check("alu_single_ready", alu_ready, 1'b1);
    check("busy5_before_xfer", busy[5], 1'b1);
    step();
    alu_valid = 0;
    check("wb5_write_en", write_en, 1'b1);
    check("wb5_rd_addr", rd_addr, 5'd5);
    check("wb5_rd_data", rd_data, 32'hDEADBEEF);
    check("wb5_busy_cleared", busy[5], 1'b0);
    step();
    check("wb5_single_pulse", write_en, 1'b0);

    rst = 1'b0; #2; rst = 1'b1;
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_alu_ready", alu_ready, exp_alu[i]);
      check("rr_lsu_ready", lsu_ready, !exp_alu[i]);
      step();
      check("rr_write_en", write_en, 1'b1);
      check("rr_rd_addr", rd_addr, exp_rd[i]);
      check("rr_rd_data", rd_data, exp_alu[i] ? 32'hA1 : 32'hB2);
    end
    alu_valid = 0; lsu_valid = 0;
    step();
    check("rr_idle_write_en", write_en, 1'b0);

    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234; #1;
    check("x0_lsu_ready", lsu_ready, 1'b1);
    step();
    lsu_valid = 0;
    check("x0_write_en", write_en, 1'b0);
    check("x0_rd_addr_kept", rd_addr, 5'd2);

    issue_valid = 1; issue_rd = 0;
    step();
    issue_valid = 0;
    check("issue0_busy", busy, 32'd0);

    issue_valid = 1; issue_rd = 7;
    step();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    step();
    issue_valid = 0; issue_rd = 0; alu_valid = 0;
    check("setclr_busy7", busy[7], 1'b1);
    check("setclr_write_en", write_en, 1'b1);
    check("setclr_rd_addr", rd_addr, 5'd7);
    rs1_addr = 7; #1;
    check("setclr_hazard_rs1", hazard, 1'b1);
    rs1_addr = 0; issue_valid = 1; issue_rd = 7; #1;
    check("issue_rd_hazard", hazard, 1'b1);
    issue_rd = 4; #1;
    check("issue_rd_no_hazard", hazard, 1'b0);
    issue_valid = 0; issue_rd = 0;

    issue_valid = 1; issue_rd = 5; alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    step();
    issue_valid = 0; issue_rd = 0; alu_rd = 9; alu_data = 32'h99;
    check("pre_rst_busy", busy, 32'h0000_00A0);
    check("pre_rst_write_en", write_en, 1'b1);
    rs2_addr = 5; #1;
    check("pre_rst_hazard", hazard, 1'b1);
    rst = 1'b0; #1;
    check("rst_busy", busy, 32'd0);
    check("rst_write_en", write_en, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_hazard", hazard, 1'b0);
    check("rst_rd_addr", rd_addr, 5'd0);
    @(posedge clk); #1;
    check("rst_hold_write_en", write_en, 1'b0);
    @(negedge clk); rst = 1'b1; #1;
    check("post_rst_alu_ready", alu_ready, 1'b1);
    step();
    alu_valid = 0; rs2_addr = 0;
    check("post_rst_write_en", write_en, 1'b1);
    check("post_rst_rd_addr", rd_addr, 5'd9);
    check("post_rst_rd_data", rd_data, 32'h99);

`ifdef WB_BYPASS_EN
    issue_valid = 1; issue_rd = 3;
    step();
    issue_valid = 0; issue_rd = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h55;
    step();
    alu_valid = 0; rs2_addr = 3; #1;
    check("byp_rs2_fwd", rs2_fwd, 1'b1);
    check("byp_fwd_data", fwd_data, 32'h55);
    check("byp_hazard", hazard, 1'b0);
    check("byp_rs1_fwd", rs1_fwd, 1'b0);
    step();
    check("byp_rs2_fwd_drop", rs2_fwd, 1'b0);
    rs2_addr = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
